mcycle_unit: RTL
================

// Module: mcycle_unit
// PURPOSE
//   Iterative multi-cycle multiply/divide execution unit. Receives Start/MCycleOp from the
//   instruction decoder (MUL when op=0, unsigned DIV when op=1), computes over WIDTH cycles
//   with a shift-add / restoring-division datapath, and raises Busy so the core stalls until
//   Result1/Result2 are valid. Sits beside the ALU in the execute stage.
// PARAMETERS
//   WIDTH  32  operand width in bits; iteration count = WIDTH
// PORTS
//   CLK        in   1      single clock, rising edge
//   RESETn     in   1      synchronous, active-low reset
//   Start      in   1      request new operation (decoder Start_MCycle)
//   MCycleOp   in   1      0 = unsigned multiply, 1 = unsigned divide
//   Operand1   in   WIDTH  multiplicand / dividend
//   Operand2   in   WIDTH  multiplier / divisor
//   Result1    out  WIDTH  MUL: product[WIDTH-1:0];      DIV: quotient
//   Result2    out  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder
//   Busy       out  1      operation in progress; core must hold the instruction
// BEHAVIOUR
//   - Reset (RESETn=0 at CLK edge): state=IDLE, counter=0, Result1=Result2=0, Busy=0.
//     Reset mid-operation aborts; partial results discarded, outputs go to 0.
//   - States: IDLE, COMPUTE.
//     IDLE: Start=1 -> latch Operand1/Operand2/MCycleOp, clear accumulators, counter=0,
//       go COMPUTE. Start=0 -> stay; Result1/Result2 hold last values.
//     COMPUTE: one iteration per edge; counter increments; after iteration WIDTH
//       (counter==WIDTH-1 at the edge) write Result1/Result2, go IDLE.
//   - Busy = (state==IDLE && Start) || (state==COMPUTE). Combinational in the Start cycle
//     so the core stalls immediately.
//   - Latency: Start seen in cycle 0 -> Busy high cycles 0..WIDTH (WIDTH+1 cycles);
//     results valid and Busy=0 from cycle WIDTH+1. Core must hold Start/operands stable
//     while Busy; unit uses only the cycle-0 latched copies.
//   - MUL: 2*WIDTH-bit unsigned shift-add; each iteration: if multiplier LSB=1 add
//     multiplicand into upper half, then shift {acc} right by 1 with carry-in.
//     Full 2*WIDTH product; no overflow possible.
//   - DIV: restoring division on {remainder,quotient} register of 2*WIDTH+1 bits; each
//     iteration shift left 1, trial-subtract divisor from upper part, keep if non-negative
//     and set quotient LSB=1, else restore and set 0.
//   - Divide by zero: Result1=all ones, Result2=Operand1; same WIDTH+1 latency, no error flag.
//   - Start while in COMPUTE: ignored (no restart, no re-latch).
//   - Start held high in the cycle results appear (back-to-back): that cycle is IDLE, so a
//     new operation starts; Busy stays high with no gap cycle. Core deasserts Start on
//     the first cycle Busy=0 to avoid re-issue.
//   - Result1/Result2 change only at the completing edge or reset; never mid-operation.
// TESTING
//   1. MUL 7 x 6 -> Busy high 33 cycles; then Result1=0x0000002A, Result2=0x00000000.
//   2. MUL 0xFFFFFFFF x 0xFFFFFFFF -> Result1=0x00000001, Result2=0xFFFFFFFE.
//   3. DIV 100 / 7 -> Result1=0x0000000E, Result2=0x00000002; DIV 5/9 -> Result1=0, Result2=5.
//   4. DIV 0x12345678 / 0 -> Result1=0xFFFFFFFF, Result2=0x12345678, latency 33 cycles.
//   5. Start MUL 3x4, change operands and pulse Start at cycle 10 -> ignored;
//      Result1=0x0000000C at cycle 33.
//   6. RESETn=0 at cycle 15 of a DIV -> next edge Busy=0, Result1=Result2=0, state IDLE;
//      a fresh MUL 2x3 then completes normally with Result1=6.

Source files
------------

// File: rtl/mcycle_unit.sv
// Iterative unsigned multiply / divide unit for the execute stage.
// One shift-add or restoring-division step per clock, WIDTH steps per op.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = 2 * WIDTH;

    typedef enum logic {
        IDLE,
        COMPUTE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] res1_q, res1_d;
    logic [WIDTH-1:0] res2_q, res2_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_hi;
    logic [WIDTH:0]   div_trial;
    logic [AW-1:0]    step;

    always_comb begin
        // MUL: acc = {product_hi, multiplier}; opb holds the multiplicand
        mul_sum = {1'b0, acc_q[AW-1:WIDTH]};
        if (acc_q[0]) begin
            mul_sum = mul_sum + {1'b0, opb_q};
        end
        // DIV: acc = {remainder, quotient}; opb holds the divisor
        div_hi    = acc_q[AW-1:WIDTH-1];
        div_trial = div_hi - {1'b0, opb_q};
        if (op_q) begin
            if (div_trial[WIDTH]) begin
                step = {acc_q[AW-2:0], 1'b0};
            end else begin
                step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = COMPUTE;
                    count_d = '0;
                    op_d    = MCycleOp;
                    opb_d   = MCycleOp ? Operand2 : Operand1;
                    acc_d   = {{WIDTH{1'b0}}, MCycleOp ? Operand1 : Operand2};
                end
            end
            COMPUTE: begin
                acc_d   = step;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    count_d = '0;
                    res1_d  = step[WIDTH-1:0];
                    res2_d  = step[AW-1:WIDTH];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= 1'b0;
            opb_q   <= '0;
            acc_q   <= '0;
            res1_q  <= '0;
            res2_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
        end
    end

    assign Busy    = (state_q == COMPUTE) || ((state_q == IDLE) && Start);
    assign Result1 = res1_q;
    assign Result2 = res2_q;

endmodule
